ste_xadc_sampler: RTL and testbench

Periodic sample source that feeds the averaging filter's `din_i`/`din_update_i` input. It reads one XADC conversion result over the DRP port at a fixed rate, right-justifies the 12-bit code into `DATA_W` bits, and presents it with a single-cycle update strobe. It sits between the XADC primitive and `ste_avg_fir` in the multimeter measurement path.

---
 rtl/ste_pkg.sv | 21 ++
 rtl/ste_xadc_sampler_if.sv | 21 ++
 rtl/ste_tick_gen.sv | 33 +++
 rtl/ste_xadc_sampler.sv | 93 +++++++++
 tb/tb_ste_xadc_sampler.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ste_pkg.sv
// Shared types and constants for the ste measurement path.
// xadc_state_t is also exported from the sampler as a debug output.
package ste_pkg;

  typedef enum logic [1:0] {
    XADC_IDLE = 2'd0,
    XADC_REQ  = 2'd1,
    XADC_WAIT = 2'd2,
    XADC_EMIT = 2'd3
  } xadc_state_t;

  localparam int XADC_RES_MSB = 15;
  localparam int XADC_RES_LSB = 4;
  localparam int XADC_RES_W   = XADC_RES_MSB - XADC_RES_LSB + 1;

  // The XADC result registers hold a left-justified 12-bit code.
  function automatic logic [XADC_RES_W-1:0] xadc_code(input logic [15:0] drp_word);
    return drp_word[XADC_RES_MSB:XADC_RES_LSB];
  endfunction

endpackage

// File: rtl/ste_xadc_sampler_if.sv
// DRP port between the sampler (master) and the XADC primitive (slave).
// Handshake: drp_den_o is a one-cycle read request; drp_do_i is valid only in the
// cycle drp_drdy_i is high, and the master accepts it only while a read is pending.
interface ste_xadc_sampler_if;
  logic        drp_den_o;
  logic        drp_dwe_o;
  logic [6:0]  drp_daddr_o;
  logic [15:0] drp_di_o;
  logic [15:0] drp_do_i;
  logic        drp_drdy_i;

  modport master (
    output drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o,
    input  drp_do_i, drp_drdy_i
  );

  modport slave (
    input  drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o,
    output drp_do_i, drp_drdy_i
  );
endinterface

// File: rtl/ste_tick_gen.sv
// Rate divider: one-cycle registered tick every DIV enabled cycles.
// Dropping en or pulsing clr restarts the count from zero.
module ste_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clr || !en) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == CW'(DIV - 1)) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/ste_xadc_sampler.sv
// Periodic XADC reader: one DRP read per tick, right-justified sample with a
// single-cycle update strobe, plus sticky overrun/timeout flags.
module ste_xadc_sampler
  import ste_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          SAMPLE_DIV  = 100000,
  parameter logic [6:0]  CH_ADDR     = 7'h16,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic                clr_err_i,
  ste_xadc_sampler_if.master  drp,
  output logic [DATA_W-1:0]   dout_o,
  output logic                dout_update_o,
  output logic                overrun_o,
  output logic                timeout_o,
  output xadc_state_t         state_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  xadc_state_t   state;
  logic          tick;
  logic          den_q;
  logic [TW-1:0] wait_cnt;

  ste_tick_gen #(.DIV(SAMPLE_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (enable_i),
    .clr   (1'b0),
    .tick  (tick)
  );

  assign drp.drp_den_o   = den_q;
  assign drp.drp_dwe_o   = 1'b0;
  assign drp.drp_daddr_o = CH_ADDR;
  assign drp.drp_di_o    = 16'h0000;
  assign state_o         = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= XADC_IDLE;
      den_q         <= 1'b0;
      wait_cnt      <= '0;
      dout_o        <= '0;
      dout_update_o <= 1'b0;
      overrun_o     <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      den_q         <= 1'b0;
      dout_update_o <= 1'b0;

      // A tick that finds a read still outstanding is dropped, not queued.
      if (tick && state != XADC_IDLE) overrun_o <= 1'b1;
      else if (clr_err_i)             overrun_o <= 1'b0;

      // A timeout set further down in the same cycle overrides this clear.
      if (clr_err_i) timeout_o <= 1'b0;

      case (state)
        XADC_IDLE: begin
          if (tick) begin
            den_q <= 1'b1;
            state <= XADC_REQ;
          end
        end
        XADC_REQ: begin
          wait_cnt <= '0;
          state    <= XADC_WAIT;
        end
        XADC_WAIT: begin
          if (drp.drp_drdy_i) begin
            dout_o        <= DATA_W'(xadc_code(drp.drp_do_i));
            dout_update_o <= 1'b1;
            state         <= XADC_EMIT;
          end else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
            timeout_o <= 1'b1;
            state     <= XADC_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        XADC_EMIT: state <= XADC_IDLE;
        default:   state <= XADC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ste_xadc_sampler.sv
// Bench for ste_xadc_sampler: two instances (short and long DRP timeout) share
// stimulus; each has its own DRP responder and a transaction-level expectation model.
module tb_ste_xadc_sampler;
  import ste_pkg::*;

  localparam int DIV  = 10;
  localparam int TO_A = 8;
  localparam int TO_B = 255;
  localparam int NRD  = 128;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n     = 1'b0;
  logic enable_i  = 1'b0;
  logic clr_err_i = 1'b0;

  ste_xadc_sampler_if bus_a ();
  ste_xadc_sampler_if bus_b ();

  logic [15:0] dout_s [2];
  logic        upd_s  [2];
  logic        ovr_s  [2];
  logic        to_s   [2];
  logic        den_s  [2];
  xadc_state_t st_s   [2];

  ste_xadc_sampler #(.DATA_W(16), .SAMPLE_DIV(DIV), .CH_ADDR(7'h16), .TIMEOUT_CYC(TO_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .clr_err_i(clr_err_i), .drp(bus_a),
    .dout_o(dout_s[0]), .dout_update_o(upd_s[0]), .overrun_o(ovr_s[0]),
    .timeout_o(to_s[0]), .state_o(st_s[0])
  );

  ste_xadc_sampler #(.DATA_W(16), .SAMPLE_DIV(DIV), .CH_ADDR(7'h16), .TIMEOUT_CYC(TO_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .clr_err_i(clr_err_i), .drp(bus_b),
    .dout_o(dout_s[1]), .dout_update_o(upd_s[1]), .overrun_o(ovr_s[1]),
    .timeout_o(to_s[1]), .state_o(st_s[1])
  );

  // DRP responders: read j answers lat_tab[i][j] cycles after den (0 = never)
  int          lat_tab [2][NRD];
  logic [15:0] dat_tab [2][NRD];
  int          cd      [2] = '{0, 0};
  int          dcnt    [2] = '{0, 0};
  logic [15:0] pend    [2] = '{16'h0, 16'h0};
  logic        drdy_s  [2] = '{1'b0, 1'b0};
  logic [15:0] do_s    [2] = '{16'h0, 16'h0};
  logic        stray_s [2] = '{1'b0, 1'b0};
  logic [15:0] stray_dat = 16'h1230;

  assign den_s[0] = bus_a.drp_den_o;
  assign den_s[1] = bus_b.drp_den_o;
  assign bus_a.drp_drdy_i = drdy_s[0] | stray_s[0];
  assign bus_b.drp_drdy_i = drdy_s[1] | stray_s[1];
  assign bus_a.drp_do_i   = stray_s[0] ? stray_dat : do_s[0];
  assign bus_b.drp_do_i   = stray_s[1] ? stray_dat : do_s[1];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      drdy_s[i] = 1'b0;
      do_s[i]   = 16'($urandom);
      if (cd[i] > 0) begin
        cd[i]--;
        if (cd[i] == 0) begin
          drdy_s[i] = 1'b1;
          do_s[i]   = pend[i];
        end
      end
      if (den_s[i] === 1'b1) begin
        if (lat_tab[i][dcnt[i]] > 0) begin
          cd[i]   = lat_tab[i][dcnt[i]];
          pend[i] = dat_tab[i][dcnt[i]];
        end
        if (dcnt[i] < NRD - 1) dcnt[i]++;
      end
    end
  end

  // reference model: ticks, read outcomes and flags derived from the rules
  int          n = 0;
  int          run       [2];
  int          idle_from [2];
  int          den_at    [2];
  int          strobe_at [2];
  int          to_at     [2];
  int          rd        [2] = '{0, 0};
  bit          ovr_next  [2];
  logic [15:0] sdat      [2];
  logic [15:0] e_dout    [2];
  bit          e_ovr     [2];
  bit          e_to      [2];
  int          to_cyc    [2] = '{TO_A, TO_B};

  int          n_assert = 0;
  int          n_fail   = 0;
  int          den_cyc_a [$];
  int          upd_cyc_a [$];
  logic [15:0] got_a     [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_cycle(input int i, input bit rst_p, input bit en_p, input bit clr_p);
    int lat;
    if (!rst_p) begin
      run[i] = 0; idle_from[i] = 0; den_at[i] = -1; strobe_at[i] = -1; to_at[i] = -1;
      ovr_next[i] = 0; e_dout[i] = 16'h0; e_ovr[i] = 0; e_to[i] = 0;
      return;
    end
    run[i] = en_p ? run[i] + 1 : 0;
    if (ovr_next[i]) e_ovr[i] = 1; else if (clr_p) e_ovr[i] = 0;
    ovr_next[i] = 0;
    if (to_at[i] == n) e_to[i] = 1; else if (clr_p) e_to[i] = 0;
    if (strobe_at[i] == n) e_dout[i] = {4'h0, sdat[i][15:4]};
    if (run[i] > 0 && run[i] % DIV == 0) begin
      if (n >= idle_from[i]) begin
        lat = lat_tab[i][rd[i]];
        sdat[i] = dat_tab[i][rd[i]];
        if (rd[i] < NRD - 1) rd[i]++;
        den_at[i] = n + 1;
        if (lat >= 1 && lat <= to_cyc[i]) begin
          strobe_at[i] = n + 2 + lat;
          idle_from[i] = n + 3 + lat;
        end else begin
          to_at[i]     = n + 2 + to_cyc[i];
          idle_from[i] = n + 2 + to_cyc[i];
        end
      end else begin
        ovr_next[i] = 1;
      end
    end
  endtask

  // advance one cycle, then compare every output of both instances
  task automatic step();
    bit en_p, clr_p, rst_p;
    en_p = enable_i; clr_p = clr_err_i; rst_p = rst_n;
    @(posedge clk);
    #1;
    n++;
    for (int i = 0; i < 2; i++) begin
      model_cycle(i, rst_p, en_p, clr_p);
      chk($sformatf("den_%0d@%0d", i, n), 32'(den_s[i]), 32'(den_at[i] == n));
      chk($sformatf("upd_%0d@%0d", i, n), 32'(upd_s[i]), 32'(strobe_at[i] == n));
      chk($sformatf("dout_%0d@%0d", i, n), 32'(dout_s[i]), 32'(e_dout[i]));
      chk($sformatf("overrun_%0d@%0d", i, n), 32'(ovr_s[i]), 32'(e_ovr[i]));
      chk($sformatf("timeout_%0d@%0d", i, n), 32'(to_s[i]), 32'(e_to[i]));
    end
    if (den_s[0] === 1'b1) den_cyc_a.push_back(n);
    if (upd_s[0] === 1'b1) begin
      upd_cyc_a.push_back(n);
      got_a.push_back(dout_s[0]);
    end
  endtask

  initial begin
    int r, d, e, nu, nd;
    bit found;

    // stimulus tables: directed reads first, random afterwards
    for (int j = 0; j < NRD; j++) begin
      lat_tab[0][j] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
      dat_tab[0][j] = 16'($urandom);
      lat_tab[1][j] = int'($urandom_range(1, 20));
      dat_tab[1][j] = 16'($urandom);
    end
    lat_tab[0][0] = 3; dat_tab[0][0] = 16'hABC0;
    lat_tab[0][1] = 3; dat_tab[0][1] = 16'hABC0;
    lat_tab[0][2] = 3; dat_tab[0][2] = 16'hFFFF;
    lat_tab[0][3] = 3; dat_tab[0][3] = 16'h000F;
    lat_tab[0][4] = 0;
    lat_tab[0][5] = 4;
    for (int j = 0; j < 4; j++) lat_tab[1][j] = 12;

    // reset values
    rst_n = 1'b0; enable_i = 1'b1; clr_err_i = 1'b0;
    repeat (3) step();
    chk("reset_state_a", 32'(st_s[0]), 32'(XADC_IDLE));
    chk("reset_dout_a", 32'(dout_s[0]), 32'h0);
    chk("daddr_a", 32'(bus_a.drp_daddr_o), 32'h16);
    chk("dwe_a", 32'(bus_a.drp_dwe_o), 32'h0);
    chk("di_a", 32'(bus_a.drp_di_o), 32'h0);
    chk("daddr_b", 32'(bus_b.drp_daddr_o), 32'h16);

    // four directed reads on A (latency 3); B runs latency 12 and overruns
    rst_n = 1'b1;
    r = n;
    repeat (46) step();
    chk("strobe_count_a", 32'(got_a.size()), 32'd4);
    chk("sample0_a", 32'(got_a[0]), 32'h0ABC);
    chk("sample1_a", 32'(got_a[1]), 32'h0ABC);
    chk("sample2_a", 32'(got_a[2]), 32'h0FFF);
    chk("sample3_a", 32'(got_a[3]), 32'h0000);
    chk("first_den_a", 32'(den_cyc_a[0] - r), 32'(DIV + 1));
    chk("tick_to_strobe_a", 32'(upd_cyc_a[0] - den_cyc_a[0] + 1), 32'd5);
    chk("strobe_spacing_a", 32'(upd_cyc_a[1] - upd_cyc_a[0]), 32'(DIV));
    chk("overrun_b", 32'(ovr_s[1]), 32'h1);

    // read 4 on A never answers: timeout, no strobe, next tick still reads
    repeat (15) step();
    chk("timeout_a", 32'(to_s[0]), 32'h1);
    chk("no_strobe_on_timeout_a", 32'(upd_cyc_a.size()), 32'd4);
    chk("den_after_timeout_a", 32'(den_cyc_a.size()), 32'd6);
    clr_err_i = 1'b1;
    step();
    clr_err_i = 1'b0;
    step();
    chk("timeout_cleared_a", 32'(to_s[0]), 32'h0);

    // random enable / clear traffic
    for (int k = 0; k < 300; k++) begin
      enable_i  = ($urandom_range(0, 15) != 0);
      clr_err_i = ($urandom_range(0, 19) == 0);
      step();
    end

    // drain, then reset in the middle of a read whose drdy arrives afterwards
    enable_i = 1'b0; clr_err_i = 1'b0;
    repeat (30) step();
    lat_tab[0][rd[0]] = 7;
    lat_tab[1][rd[1]] = 15;
    enable_i = 1'b1;
    nd = den_cyc_a.size();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      found = (den_cyc_a.size() != nd);
    end
    chk("den_before_reset_a", 32'(found), 32'h1);
    d = n;
    repeat (3) step();
    chk("in_wait_a", 32'(st_s[0]), 32'(XADC_WAIT));
    rst_n = 1'b0; enable_i = 1'b0;
    repeat (2) step();
    chk("midread_reset_state_a", 32'(st_s[0]), 32'(XADC_IDLE));
    chk("midread_reset_dout_a", 32'(dout_s[0]), 32'h0);
    rst_n = 1'b1;

    // enable low for 50 cycles; late drdy and a stray drdy must be ignored
    nu = upd_cyc_a.size();
    nd = den_cyc_a.size();
    for (int k = 0; k < 50; k++) begin
      stray_s[0] = (k == 20);
      stray_s[1] = (k == 20);
      step();
    end
    stray_s[0] = 1'b0; stray_s[1] = 1'b0;
    chk("no_strobe_after_reset_a", 32'(upd_cyc_a.size()), 32'(nu));
    chk("no_den_while_disabled_a", 32'(den_cyc_a.size()), 32'(nd));
    chk("late_drdy_seen_a", 32'(n - d > 7), 32'h1);

    // re-enable: first den SAMPLE_DIV+1 cycles later
    enable_i = 1'b1;
    e = n;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      found = (den_cyc_a.size() != nd);
    end
    chk("den_after_reenable_found_a", 32'(found), 32'h1);
    chk("den_after_reenable_a", 32'(den_cyc_a[den_cyc_a.size() - 1] - e), 32'(DIV + 1));
    repeat (30) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
